// File: rtl/hit_pkg.sv
// Shared types and default constants for the hit-sensor input conditioner.
// The debounce FSM state encoding lives here so benches and tools share one definition.
package hit_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbnc_state_t;

    localparam int HIT_DEBOUNCE_CYCLES = 1000000;
    localparam int HIT_SYNC_STAGES     = 2;

endpackage

// File: rtl/debounce_channel.sv
// One input line: synchronizer, debounce FSM with stability counter, and registered
// level / press / release outputs.
module debounce_channel
    import hit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = HIT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = HIT_SYNC_STAGES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW}};

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    dbnc_state_t            state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   press_reg, press_next;
    logic                   release_reg, release_next;

    // Synchronizer resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= SYNC_IDLE;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RELEASED;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RELEASED: if (s) begin
                state_next = PRESS_WAIT;
                cnt_next   = CW'(1);
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            PRESSED: if (!s) begin
                state_next = RELEASE_WAIT;
                cnt_next   = CW'(1);
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // Pulses fire only on the acceptance cycle; en never delays an acceptance.
    always_comb begin
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (state_reg == PRESS_WAIT && s && cnt_reg == CNT_LAST) begin
            level_next = 1'b1;
            press_next = en;
        end else if (state_reg == RELEASE_WAIT && !s && cnt_reg == CNT_LAST) begin
            level_next   = 1'b0;
            release_next = en;
        end
    end

    assign level         = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;

endmodule

// File: rtl/hit_input_conditioner.sv
// Input stage for the reaction game: N_CH independent debounced hit lines,
// each producing a clean level plus one-cycle press/release pulses.
module hit_input_conditioner
    import hit_pkg::*;
#(
    parameter int N_CH            = 1,
    parameter int DEBOUNCE_CYCLES = HIT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = HIT_SYNC_STAGES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    input  logic            en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES),
                .ACTIVE_LOW     (ACTIVE_LOW)
            ) u_ch (
                .clk          (clk),
                .reset        (reset),
                .raw          (raw_in[gi]),
                .en           (en),
                .level        (level[gi]),
                .press_pulse  (press_pulse[gi]),
                .release_pulse(release_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_hit_input_conditioner.sv
// Directed scenarios plus a random soak for hit_input_conditioner, checked every
// cycle against a run-length reference model of the debounce rules.
module tb_hit_input_conditioner;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int S  = 2;
    localparam int LAT = S + D;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic         en;
    logic [N-1:0] level, press_pulse, release_pulse;

    hit_input_conditioner #(
        .N_CH(N), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .en(en),
        .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw samples delayed S cycles, then a change is accepted once
    // the pressed-ness has disagreed with the current level for D samples in a row.
    logic [N-1:0] pipe [S];
    logic [N-1:0] m_level, m_press, m_release;
    int           run [N];

    int cyc_idx;
    int press_cnt [N];
    int rel_cnt [N];
    int first_press [N];
    int first_rel [N];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < S; k++) pipe[k] = '1;
        m_level = '0; m_press = '0; m_release = '0;
        for (int c = 0; c < N; c++) run[c] = 0;
    endtask

    task automatic model_step();
        logic pressed_now;
        m_press = '0; m_release = '0;
        for (int c = 0; c < N; c++) begin
            pressed_now = ~pipe[S-1][c];
            if (pressed_now != m_level[c]) run[c]++;
            else run[c] = 0;
            if (run[c] == D) begin
                m_level[c] = pressed_now;
                if (pressed_now) m_press[c] = en;
                else m_release[c] = en;
                run[c] = 0;
            end
        end
        for (int k = S - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = raw_in;
    endtask

    task automatic clear_tally();
        cyc_idx = 0;
        for (int c = 0; c < N; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; first_press[c] = -1; first_rel[c] = -1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        cyc_idx++;
        for (int c = 0; c < N; c++) begin
            check_bit($sformatf("level[%0d]@%0t", c, $time), level[c], m_level[c]);
            check_bit($sformatf("press[%0d]@%0t", c, $time), press_pulse[c], m_press[c]);
            check_bit($sformatf("release[%0d]@%0t", c, $time), release_pulse[c], m_release[c]);
            check_bit($sformatf("excl[%0d]@%0t", c, $time), press_pulse[c] & release_pulse[c], 1'b0);
            if (press_pulse[c] === 1'b1) begin
                press_cnt[c]++;
                if (first_press[c] < 0) first_press[c] = cyc_idx;
            end
            if (release_pulse[c] === 1'b1) begin
                rel_cnt[c]++;
                if (first_rel[c] < 0) first_rel[c] = cyc_idx;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        raw_in = 2'b11; en = 1'b1; reset = 1'b0;
        model_reset();
        clear_tally();

        // Reset asserted mid-clock with lines idle
        #3 reset = 1'b1;
        #1;
        check_int("reset_level", int'(level), 0);
        check_int("reset_press", int'(press_pulse), 0);
        check_int("reset_release", int'(release_pulse), 0);
        run_cycles(3);
        reset = 1'b0;
        run_cycles(5);
        check_int("post_reset_level", int'(level), 0);

        // Clean press on ch0
        clear_tally();
        raw_in[0] = 1'b0;
        run_cycles(20);
        check_int("clean_press_cnt0", press_cnt[0], 1);
        check_int("clean_press_at0", first_press[0], LAT);
        check_int("clean_press_cnt1", press_cnt[1], 0);
        check_bit("clean_level0", level[0], 1'b1);

        // Release ch0
        clear_tally();
        raw_in[0] = 1'b1;
        run_cycles(20);
        check_int("release_cnt0", rel_cnt[0], 1);
        check_int("release_at0", first_rel[0], LAT);
        check_bit("release_level0", level[0], 1'b0);

        // Bounce: 3 low, 2 high, then held low
        clear_tally();
        raw_in[0] = 1'b0;
        run_cycles(3);
        raw_in[0] = 1'b1;
        run_cycles(2);
        clear_tally();
        raw_in[0] = 1'b0;
        run_cycles(20);
        check_int("bounce_press_cnt", press_cnt[0], 1);
        check_int("bounce_press_at", first_press[0], LAT);

        // Release, then press with en=0: level follows, pulse suppressed
        raw_in[0] = 1'b1;
        run_cycles(20);
        clear_tally();
        en = 1'b0;
        raw_in[0] = 1'b0;
        run_cycles(20);
        check_int("gated_press_cnt", press_cnt[0], 0);
        check_bit("gated_level0", level[0], 1'b1);
        en = 1'b1;
        raw_in[0] = 1'b1;
        run_cycles(20);

        // Reset mid-debounce, press held through it
        clear_tally();
        raw_in[0] = 1'b0;
        run_cycles(4);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_int("mid_reset_level", int'(level), 0);
        check_int("mid_reset_press", int'(press_pulse), 0);
        run_cycles(2);
        check_int("mid_reset_no_pulse", press_cnt[0], 0);
        reset = 1'b0;
        clear_tally();
        run_cycles(20);
        check_int("after_reset_press_cnt", press_cnt[0], 1);
        check_int("after_reset_press_at", first_press[0], LAT);

        // Simultaneous presses on both channels
        raw_in = 2'b11;
        run_cycles(20);
        clear_tally();
        raw_in = 2'b00;
        run_cycles(20);
        check_int("simul_cnt0", press_cnt[0], 1);
        check_int("simul_cnt1", press_cnt[1], 1);
        check_int("simul_at0", first_press[0], LAT);
        check_int("simul_at1", first_press[1], LAT);

        // Random soak against the model
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 4) == 0) raw_in[c] = ~raw_in[c];
            en = ($urandom_range(0, 9) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hit_input_conditioner.md
# hit_input_conditioner

Upstream input stage for the reaction game: takes raw, asynchronous, bouncy hit-sensor/button lines from board pins. For each line it produces a synchronized, debounced level plus single-cycle press and release pulses. The score/target logic downstream consumes `press_pulse` instead of sampling the raw pin. A press held across many clock cycles therefore counts exactly once, and contact bounce never double-scores.

## Interface
- `N_CH`, default 1: number of independent input channels.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a change (10 ms at 100 MHz). Must be ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer flop depth. Must be ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means a raw level of 0 is "pressed"; 0 means a raw level of 1 is "pressed".

Ports:
- `clk` input 1: single system clock. All logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `raw_in` input N_CH: raw pin levels, asynchronous to `clk`.
- `en` input 1: pulse enable shared by all channels.
- `level` output N_CH: debounced state, 1 = pressed, regardless of `ACTIVE_LOW`.
- `press_pulse` output N_CH: one-cycle pulse on an accepted press.
- `release_pulse` output N_CH: one-cycle pulse on an accepted release.

## Operation
- Per channel: `raw_in` passes through `SYNC_STAGES` flops. It is then normalized to `s` (1 = pressed) by XOR with `ACTIVE_LOW`.
- Per-channel FSM, with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED and `s`=1: go to PRESS_WAIT, `cnt`=1.
  - PRESS_WAIT and `s`=0: return to RELEASED, `cnt`=0. This is a bounce; nothing is output.
  - PRESS_WAIT and `s`=1 and `cnt`=DEBOUNCE_CYCLES-1: go to PRESSED, set `level`=1, and set `press_pulse`=`en`.
  - PRESS_WAIT and `s`=1 otherwise: `cnt`++.
  - PRESSED and RELEASE_WAIT mirror the two rows above with `s` inverted. On acceptance: `level`=0, and `release_pulse`=`en`.
- `cnt` width is $clog2(DEBOUNCE_CYCLES). `cnt` saturates and never wraps, because the FSM leaves the WAIT state at the terminal count.
- `en` gates only the pulses. `level` and the FSM track the input regardless of `en`. A change accepted while `en`=0 is lost, not deferred.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- On a single channel, `press_pulse` and `release_pulse` are never high together. Consecutive pulses on one channel are at least DEBOUNCE_CYCLES apart.

## Timing
- Reset values: all synchronizer flops at the raw idle level (the not-pressed level). FSM in RELEASED, `cnt`=0. `level`, `press_pulse` and `release_pulse` all 0.
- All outputs are registered, with no combinational path from any input.
- Latency: a raw edge, meeting setup, appears on `s` after SYNC_STAGES edges. The accepted pulse and the `level` change then appear DEBOUNCE_CYCLES edges later. Total latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Each pulse is exactly 1 cycle wide.
- Reset asserted mid-debounce: the pending change is abandoned and outputs are 0 immediately, asynchronously. No pulse is emitted after reset.
- A press held through reset release: it debounces normally and yields one `press_pulse` (if `en`=1) at SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first post-reset edge.
- Glitches shorter than DEBOUNCE_CYCLES, after synchronization, produce no output.

## Structure
- Package `hit_pkg` holds:
  - the `dbnc_state_t` enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - the default constants `HIT_DEBOUNCE_CYCLES` and `HIT_SYNC_STAGES`.
- Sub-module `debounce_channel` holds one channel: synchronizer, FSM, counter and pulse registers. The top instantiates it N_CH times in a generate loop and fans `en`, `clk` and `reset` out to every instance.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW=1, N_CH=2, `en`=1 unless stated.
- Reset: assert `reset` with `raw_in`=2'b11, mid-clock. Outputs are 0 asynchronously and stay 0 after release.
- Clean press: ch0 `raw_in` 1→0, held 20 cycles. `press_pulse[0]`=1 for exactly one cycle, 6 cycles after the edge. `level[0]`=1 from the same cycle. ch1 stays silent.
- Bounce: ch0 low for 3 cycles, high for 2, then low and held. No pulse for the 3-cycle glitch. A single `press_pulse[0]` appears 6 cycles after the final falling edge.
- Release and enable gating:
  - Release ch0 after a press. `release_pulse[0]` appears 6 cycles later and `level[0]`→0.
  - Repeat the press with `en`=0. `level[0]`→1, no `press_pulse`.
- Reset mid-debounce: assert `reset` 4 cycles after a press edge. No pulse, `level`=0. Keep the press held after reset release: one `press_pulse` appears 6 cycles after the first post-reset edge.
- Simultaneous channels: both channels fall on the same edge. `press_pulse`=2'b11 in the same cycle, once.
